key_filter_lp: RTL and testbench

- Debounces one raw mechanical push-button (active-low) into clean single-cycle event pulses and a stable level.
- Sits directly upstream of the power-button toggle/sequencing stage.
- Its key_flag output is that stage's press-event input.
- Also provides long-press and release events for board-level control logic.

---
 rtl/key_filter_lp_if.sv | 26 ++
 rtl/key_filter_lp.sv | 150 +++++++++++++++
 tb/tb_key_filter_lp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/key_filter_lp_if.sv
// Button-side signal bundle: raw key input plus the debounced events and level.
interface key_filter_lp_if;
  logic key_in;
  logic key_flag;
  logic key_release;
  logic key_long;
  logic key_state;

  // Board/control side: drives the raw key and consumes the events.
  modport master (
    output key_in,
    input  key_flag,
    input  key_release,
    input  key_long,
    input  key_state
  );

  // Filter side: samples the raw key and produces the events.
  modport slave (
    input  key_in,
    output key_flag,
    output key_release,
    output key_long,
    output key_state
  );
endinterface

// File: rtl/key_filter_lp.sv
// Push-button debouncer: synchronises an active-low raw key, filters press and
// release over a CNT_MAX+1 cycle window, and emits press, release and
// long-press pulses plus a stable debounced level.
module key_filter_lp #(
  parameter int unsigned CNT_MAX    = 999_999,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned LONG_TICKS = 100
) (
  input logic           clk,
  input logic           rst,
  key_filter_lp_if.slave key
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    RELEASE_FILT
  } state_t;

  logic s1, s2, s3;
  logic nedge, pedge;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;

  logic flag_q, flag_nx;
  logic release_q, release_nx;
  logic long_q, long_nx;
  logic level_q, level_nx;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= key.key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign nedge = s3 & ~s2;
  assign pedge = ~s3 & s2;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      flag_q    <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      level_q   <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hold_cnt  <= hold_nx;
      flag_q    <= flag_nx;
      release_q <= release_nx;
      long_q    <= long_nx;
      level_q   <= level_nx;
    end
  end

  // Next-state and next-output logic; an opposing edge always beats window expiry.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hold_nx    = hold_cnt;
    flag_nx    = 1'b0;
    release_nx = 1'b0;
    long_nx    = 1'b0;
    level_nx   = level_q;

    case (state)
      IDLE: begin
        cnt_nx  = '0;
        hold_nx = '0;
        if (nedge) begin
          state_nx = PRESS_FILT;
        end
      end

      PRESS_FILT: begin
        if (pedge) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = DOWN;
          cnt_nx   = '0;
          flag_nx  = 1'b1;
          level_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      DOWN: begin
        if (pedge) begin
          state_nx = RELEASE_FILT;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (hold_cnt != HOLD_LAST) begin
            hold_nx = hold_cnt + HOLD_W'(1);
            long_nx = (hold_nx == HOLD_LAST);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      RELEASE_FILT: begin
        if (nedge) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          hold_nx    = '0;
          release_nx = 1'b1;
          level_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        hold_nx  = '0;
      end
    endcase
  end

  assign key.key_flag    = flag_q;
  assign key.key_release = release_q;
  assign key.key_long    = long_q;
  assign key.key_state   = level_q;

endmodule

// File: tb/tb_key_filter_lp.sv
// Directed bench for key_filter_lp with a short filter window (CNT_MAX=9,
// LONG_TICKS=3). Each run logs outputs after every edge e0..eN and compares
// pulse positions/counts and the debounced level against hand-computed edges.
module tb_key_filter_lp;

  localparam int unsigned CNT_MAX    = 9;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned LONG_TICKS = 3;
  localparam int          MAXLEN     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_filter_lp_if kif ();

  key_filter_lp #(
    .CNT_MAX    (CNT_MAX),
    .CNT_W      (CNT_W),
    .LONG_TICKS (LONG_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .key (kif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int low;
    int total;
    int exp_flag;
    int exp_rel;
    int exp_long;
  } vec_t;

  logic pat [MAXLEN];
  logic lf  [MAXLEN];
  logic lr  [MAXLEN];
  logic ll  [MAXLEN];
  logic ls  [MAXLEN];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_low(input int low, input int total);
    for (int i = 0; i < total; i++) pat[i] = (i < low) ? 1'b0 : 1'b1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " key_flag"},    int'(kif.key_flag),    0);
    check({name, " key_release"}, int'(kif.key_release), 0);
    check({name, " key_long"},    int'(kif.key_long),    0);
    check({name, " key_state"},   int'(kif.key_state),   1);
  endtask

  task automatic do_reset(input string name);
    rst        = 1'b1;
    kif.key_in = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs({name, " reset"});
    rst = 1'b0;
  endtask

  // Apply pat[0..total-1]; entry i is the value sampled at edge e_i.
  task automatic run(input int total);
    for (int i = 0; i < total; i++) begin
      kif.key_in = pat[i];
      @(posedge clk);
      #1;
      lf[i] = kif.key_flag;
      lr[i] = kif.key_release;
      ll[i] = kif.key_long;
      ls[i] = kif.key_state;
    end
  endtask

  task automatic evaluate(input string name, input int total,
                          input int ef, input int er, input int el);
    int f_first, f_cnt, r_first, r_cnt, l_first, l_cnt, st_err, both;
    logic exp_state;
    f_first = -1; r_first = -1; l_first = -1;
    f_cnt = 0; r_cnt = 0; l_cnt = 0; st_err = 0; both = 0;
    for (int i = 0; i < total; i++) begin
      if (lf[i]) begin f_cnt++; if (f_first < 0) f_first = i; end
      if (lr[i]) begin r_cnt++; if (r_first < 0) r_first = i; end
      if (ll[i]) begin l_cnt++; if (l_first < 0) l_first = i; end
      if (lf[i] && lr[i]) both++;
      exp_state = (ef >= 0 && i >= ef && (er < 0 || i < er)) ? 1'b0 : 1'b1;
      if (ls[i] !== exp_state) st_err++;
    end
    check({name, " flag_edge"},    f_first, ef);
    check({name, " flag_count"},   f_cnt,   (ef >= 0) ? 1 : 0);
    check({name, " release_edge"}, r_first, er);
    check({name, " release_count"}, r_cnt,  (er >= 0) ? 1 : 0);
    check({name, " long_edge"},    l_first, el);
    check({name, " long_count"},   l_cnt,   (el >= 0) ? 1 : 0);
    check({name, " state_errors"}, st_err,  0);
    check({name, " flag_release_overlap"}, both, 0);
  endtask

  initial begin
    vec_t vecs [8];

    // {low cycles, logged cycles, flag edge, release edge, long edge}
    vecs[0] = '{20, 40, 12, 32, -1};  // clean press, release later
    vecs[1] = '{15, 40, 12, 27, -1};  // short hold, no long press
    vecs[2] = '{60, 80, 12, 72, 42};  // long press fires once
    vecs[3] = '{ 2, 20, -1, -1, -1};  // glitch never reaches window end
    vecs[4] = '{10, 30, -1, -1, -1};  // pedge coincides with window end: bounce wins
    vecs[5] = '{11, 30, 12, 23, -1};  // one cycle longer: press confirmed
    vecs[6] = '{40, 60, 12, 52, -1};  // release edge coincides with last wrap: no long
    vecs[7] = '{41, 60, 12, 53, 42};  // last wrap one cycle before release edge

    kif.key_in = 1'b1;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("power_on");
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_reset($sformatf("vec%0d", v));
      build_low(vecs[v].low, vecs[v].total);
      run(vecs[v].total);
      evaluate($sformatf("vec%0d", v), vecs[v].total,
               vecs[v].exp_flag, vecs[v].exp_rel, vecs[v].exp_long);
    end

    // Press bounce: low 5, high 2, low 3, then high; then a clean press without reset.
    do_reset("bounce");
    for (int i = 0; i < 30; i++) pat[i] = 1'b1;
    for (int i = 0; i < 5; i++)  pat[i] = 1'b0;
    for (int i = 7; i < 10; i++) pat[i] = 1'b0;
    run(30);
    evaluate("bounce", 30, -1, -1, -1);
    build_low(20, 40);
    run(40);
    evaluate("after_bounce", 40, 12, 32, -1);

    // Release bounce while held: high at e17..e20, low again until e59.
    do_reset("hold_bounce");
    build_low(60, 80);
    for (int i = 17; i < 21; i++) pat[i] = 1'b1;
    run(80);
    evaluate("hold_bounce", 80, 12, 72, 53);

    // Reset in PRESS_FILT at cnt=5 with the key still down, then a fresh press.
    do_reset("rst_filt");
    build_low(8, 8);
    run(8);
    rst        = 1'b1;
    kif.key_in = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("rst_filt abort");
    rst = 1'b0;
    build_low(20, 40);
    run(40);
    evaluate("rst_filt fresh", 40, 12, 32, -1);

    // Reset while DOWN: level must return to released and no event follows.
    do_reset("rst_down");
    build_low(20, 20);
    run(20);
    check("rst_down level_before", int'(ls[19]), 0);
    rst        = 1'b1;
    kif.key_in = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("rst_down abort");
    rst = 1'b0;
    build_low(20, 40);
    run(40);
    evaluate("rst_down fresh", 40, 12, 32, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
